// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: captures the result at start and holds it for a fixed
// busy period. The result is then committed to HI/LO, and the pipeline stalls on
// dependent MDU ops.
module mdu_sched #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdop,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_mduse,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_mdout,
  output logic        dbg_state
);

  // Handshake: the E stage presents E_mdop each cycle. A mult/div is accepted only
  // while busy=0. While busy=1, every HI/LO-affecting op is dropped.
  // The D stage must hold while stall=1.

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        done;
  logic        start;
  logic        is_div;
  logic [31:0] res_hi, res_lo;
  logic        res_skip;
  logic [31:0] calc_hi, calc_lo;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b;
  logic        div_ovf;
  logic signed [31:0] sa, sb, sq, sr;

  assign is_div = (E_mdop == MD_DIV) || (E_mdop == MD_DIVU);
  assign start  = (E_mdop >= MD_MULT) && (E_mdop <= MD_DIVU) && !busy;
  assign busy      = (state == S_BUSY);
  assign dbg_state = state;
  assign stall     = D_mduse & (start | busy);

  // Sign-extended operands give the signed product in the low 64 bits.
  assign prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Keep the divider away from x/0 and INT_MIN/-1; both are resolved by muxing.
  assign div_ovf = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
  assign div_b   = ((E_B == 32'd0) || div_ovf) ? 32'd1 : E_B;
  assign sa      = E_A;
  assign sb      = div_b;
  assign sq      = sa / sb;
  assign sr      = sa % sb;

  always_comb begin
    calc_hi = '0;
    calc_lo = '0;
    case (E_mdop)
      MD_MULT:  {calc_hi, calc_lo} = prod_s;
      MD_MULTU: {calc_hi, calc_lo} = prod_u;
      MD_DIV: begin
        if (div_ovf) begin
          calc_hi = 32'd0;
          calc_lo = 32'h8000_0000;
        end else begin
          calc_hi = sr;
          calc_lo = sq;
        end
      end
      MD_DIVU: begin
        calc_hi = E_A % div_b;
        calc_lo = E_A / div_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_BUSY;
          cnt_nxt   = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt <= 4'd1) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          done      = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      HI       <= '0;
      LO       <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      res_skip <= 1'b0;
    end else begin
      if (start) begin
        res_hi   <= calc_hi;
        res_lo   <= calc_lo;
        res_skip <= is_div && (E_B == 32'd0);
      end
      if (done) begin
        if (!res_skip) begin
          HI <= res_hi;
          LO <= res_lo;
        end
      end else if (!busy && E_mdop == MD_MTHI) begin
        HI <= E_A;
      end else if (!busy && E_mdop == MD_MTLO) begin
        LO <= E_A;
      end
    end
  end

  always_comb begin
    E_mdout = '0;
    if (E_mdop == MD_MFHI)      E_mdout = HI;
    else if (E_mdop == MD_MFLO) E_mdout = LO;
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: a scoreboard of expected {HI,LO} and busy lengths
// checked on every busy fall, plus direct checks of stall, reads and reset.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  E_mdop = '0;
  logic [31:0] E_A = '0;
  logic [31:0] E_B = '0;
  logic        D_mduse = 1'b0;
  logic        busy, stall, dbg_state;
  logic [31:0] HI, LO, E_mdout;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  int          len_q[$];

  mdu_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .E_mdop(E_mdop), .E_A(E_A), .E_B(E_B),
    .D_mduse(D_mduse), .busy(busy), .stall(stall), .HI(HI), .LO(LO),
    .E_mdout(E_mdout), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: apply inputs, let one rising edge consume them, return 1ns after it
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dm);
    E_mdop = op; E_A = a; E_B = b; D_mduse = dm;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic expect_op(input logic [31:0] hi, input logic [31:0] lo, input int len);
    exp_q.push_back({hi, lo});
    len_q.push_back(len);
  endtask

  // monitor: on each busy fall, compare busy length and {HI,LO}
  logic prev_busy = 1'b0;
  int   busy_len = 0;
  always @(negedge clk) begin
    if (busy) busy_len++;
    if (prev_busy && !busy) begin
      if (exp_q.size() == 0 || len_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: HI=%h LO=%h with empty scoreboard", HI, LO);
      end else begin
        check("result_hilo", {HI, LO}, exp_q.pop_front());
        check("busy_len", 64'(busy_len), 64'(len_q.pop_front()));
      end
      busy_len = 0;
    end
    prev_busy = busy;
  end

  initial begin
    // reset; stall follows inputs while reset is held low
    E_mdop = 4'd1; D_mduse = 1'b1;
    @(posedge clk); #1;
    check("reset_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    reset = 1'b1;
    idle(1);

    // signed and unsigned mult
    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    drive(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("start_state", 64'(dbg_state), 64'd1);
    idle(6);
    expect_op(32'h0000_0002, 32'hFFFF_FFFA, 5);
    drive(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(6);

    // signed div with D_mduse held: stall on start cycle plus 10 busy cycles
    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    E_mdop = 4'd3; E_A = 32'hFFFF_FFF9; E_B = 32'd2; D_mduse = 1'b1;
    #1;
    check("stall_start", 64'(stall), 64'd1);
    @(posedge clk); #1;
    E_mdop = 4'd0;
    for (int i = 0; i < 10; i++) begin
      check("stall_busy", 64'(stall), 64'd1);
      @(posedge clk); #1;
    end
    check("stall_after", 64'(stall), 64'd0);
    idle(2);

    // divide by zero leaves HI/LO untouched
    drive(4'd8, 32'h0000_1234, 32'd0, 1'b0);
    drive(4'd7, 32'h0000_5678, 32'd0, 1'b0);
    expect_op(32'h0000_5678, 32'h0000_1234, 10);
    drive(4'd4, 32'd99, 32'd0, 1'b0);
    idle(11);
    E_mdop = 4'd6; #1;
    check("mflo", 64'(E_mdout), 64'h1234);
    E_mdop = 4'd5; #1;
    check("mfhi", 64'(E_mdout), 64'h5678);
    E_mdop = 4'd0; #1;
    check("mdout_none", 64'(E_mdout), 64'd0);
    idle(1);

    // signed overflow divide and plain divu
    expect_op(32'h0000_0000, 32'h8000_0000, 10);
    drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(11);
    expect_op(32'h0000_0002, 32'h0000_000E, 10);
    drive(4'd4, 32'd100, 32'd7, 1'b0);
    idle(11);

    // mthi and a new start while busy are both ignored
    expect_op(32'h0000_0000, 32'h0000_001E, 5);
    drive(4'd1, 32'd5, 32'd6, 1'b0);
    drive(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check("mthi_ignored", 64'(HI), 64'h2);
    drive(4'd4, 32'd50, 32'd5, 1'b0);
    idle(6);

    // reset at busy cycle 3 aborts the op
    drive(4'd8, 32'h0000_00AA, 32'd0, 1'b0);
    expect_op(32'h0000_0000, 32'h0000_0000, 3);
    drive(4'd1, 32'd5, 32'd6, 1'b0);
    idle(2);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    idle(6);
    check("abort_no_write", {HI, LO}, 64'd0);

    // back-to-back: multu on the falling edge is ignored, accepted one edge later
    expect_op(32'h0000_0000, 32'h0000_003F, 5);
    expect_op(32'h0000_0001, 32'hFFFF_FFFE, 5);
    drive(4'd1, 32'd7, 32'd9, 1'b0);
    idle(4);
    drive(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("b2b_gap", 64'(busy), 64'd0);
    drive(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("b2b_restart", 64'(busy), 64'd1);
    idle(7);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
